// File: rtl/mbist_pkg.sv
// Shared types for the March C- BIST sequencer: FSM states, element ids and
// the per-element direction / op-pattern lookup.
package mbist_pkg;

  typedef enum logic [1:0] {IDLE, RUN, RESTART, DONE} state_e;

  typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_e;

  typedef struct packed {
    logic up;      // 1: START..END, 0: END..START
    logic has_rd;
    logic has_wr;
    logic rd_val;  // expected bit replicated across the word
    logic wr_val;  // write bit replicated across the word
  } elem_t;

  function automatic elem_t elem_info(elem_e e);
    elem_t r;
    case (e)
      E0:      r = '{up: 1'b1, has_rd: 1'b0, has_wr: 1'b1, rd_val: 1'b0, wr_val: 1'b0};
      E1:      r = '{up: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
      E2:      r = '{up: 1'b1, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
      E3:      r = '{up: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b0, wr_val: 1'b1};
      E4:      r = '{up: 1'b0, has_rd: 1'b1, has_wr: 1'b1, rd_val: 1'b1, wr_val: 1'b0};
      default: r = '{up: 1'b1, has_rd: 1'b1, has_wr: 1'b0, rd_val: 1'b0, wr_val: 1'b0};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mbist_data_cmp.sv
// Read-compare pipeline: captures expected data/address with each read strobe,
// compares against memory data one cycle later and registers the error pulse.
module mbist_data_cmp #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rd,
  input  logic [DW-1:0] exp_data,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] rdata,
  input  logic          err_en,
  output logic          mismatch,
  output logic          error,
  output logic [AW-1:0] error_addr
);

  logic          vld_q, vld_d;
  logic [DW-1:0] exp_q, exp_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          err_q, err_d;
  logic [AW-1:0] err_addr_q, err_addr_d;

  assign mismatch = vld_q && (rdata != exp_q);

  always_comb begin
    vld_d      = rd;
    exp_d      = rd ? exp_data : exp_q;
    addr_d     = rd ? addr : addr_q;
    err_d      = mismatch && err_en;
    err_addr_d = err_d ? addr_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q      <= 1'b0;
      exp_q      <= '0;
      addr_q     <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      vld_q      <= vld_d;
      exp_q      <= exp_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign error      = err_q;
  assign error_addr = err_addr_q;

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- sequencer on the BIST side of the memory mux; one op per clock,
// one repair-assisted rerun after the first mismatch.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int                      BIST_ADDR_WD    = 9,
  parameter int                      BIST_DATA_WD    = 32,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_START = 9'h000,
  parameter logic [BIST_ADDR_WD-1:0] BIST_ADDR_END   = 9'h1F8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bist_run,
  output logic                    bist_en,
  output logic [BIST_ADDR_WD-1:0] bist_addr,
  output logic [BIST_DATA_WD-1:0] bist_wdata,
  output logic                    bist_wr,
  output logic                    bist_rd,
  input  logic [BIST_DATA_WD-1:0] mem_rdata,
  input  logic                    bist_correct,
  output logic                    bist_error,
  output logic [BIST_ADDR_WD-1:0] bist_error_addr,
  output logic                    bist_busy,
  output logic                    bist_done,
  output logic                    bist_fail
);

  localparam int AW = BIST_ADDR_WD;
  localparam int DW = BIST_DATA_WD;

  state_e        state_q, state_d;
  elem_e         elem_q, elem_d, nxt_elem;
  logic [AW-1:0] addr_q, addr_d;
  logic          phase_q, phase_d;      // 1: write half of a read/write pair
  logic          drain_q, drain_d;      // waiting on the compare of the final read
  logic          restarted_q, restarted_d;
  logic          fail_q, fail_d;
  logic          run_hist_q;
  elem_t         info, nxt_info;
  logic          start, op_rd, op_wr, mismatch, cmp_en;

  assign info     = elem_info(elem_q);
  assign nxt_elem = elem_e'(3'(elem_q) + 3'd1);
  assign nxt_info = elem_info(nxt_elem);
  assign start    = bist_run && !run_hist_q;
  assign cmp_en   = (state_q == RUN) && bist_run;

  always_comb begin
    op_rd = 1'b0;
    op_wr = 1'b0;
    if (state_q == RUN && !drain_q) begin
      if (info.has_rd && info.has_wr) begin
        op_rd = !phase_q;
        op_wr = phase_q;
      end else begin
        op_rd = info.has_rd;
        op_wr = info.has_wr;
      end
    end
  end

  mbist_data_cmp #(.AW(AW), .DW(DW)) u_cmp (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd         (op_rd),
    .exp_data   ({DW{info.rd_val}}),
    .addr       (addr_q),
    .rdata      (mem_rdata),
    .err_en     (cmp_en),
    .mismatch   (mismatch),
    .error      (bist_error),
    .error_addr (bist_error_addr)
  );

  // Once a rerun has happened the repair slot is spent regardless of bist_correct.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (!bist_run)                        state_d = IDLE;
        else if (mismatch)                    state_d = (bist_correct || restarted_q) ? DONE : RESTART;
        else if (drain_q)                     state_d = DONE;
      end
      RESTART: state_d = bist_run ? RUN : IDLE;
      DONE:    if (!bist_run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    elem_d      = elem_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    drain_d     = drain_q;
    restarted_d = restarted_q;
    fail_d      = fail_q;
    if (state_d != RUN) begin
      phase_d = 1'b0;
      drain_d = 1'b0;
    end
    if (state_q != RUN && state_d == RUN) begin
      elem_d = E0;
      addr_d = BIST_ADDR_START;
    end else if (state_q == RUN && state_d == RUN && !drain_q) begin
      if (op_rd && info.has_wr) begin
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (addr_q == (info.up ? BIST_ADDR_END : BIST_ADDR_START)) begin
          if (elem_q == E5) begin
            drain_d = 1'b1;
          end else begin
            elem_d = nxt_elem;
            addr_d = nxt_info.up ? BIST_ADDR_START : BIST_ADDR_END;
          end
        end else begin
          addr_d = info.up ? addr_q + 1'b1 : addr_q - 1'b1;
        end
      end
    end
    if (state_d == RESTART) restarted_d = 1'b1;
    if (state_d == IDLE) begin
      restarted_d = 1'b0;
      fail_d      = 1'b0;
    end
    if (state_q == RUN && state_d == DONE && mismatch) fail_d = 1'b1;
  end

  // History resets high so a level already high at reset release is not a start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      elem_q      <= E0;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      drain_q     <= 1'b0;
      restarted_q <= 1'b0;
      fail_q      <= 1'b0;
      run_hist_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      drain_q     <= drain_d;
      restarted_q <= restarted_d;
      fail_q      <= fail_d;
      run_hist_q  <= bist_run;
    end
  end

  always_comb begin
    bist_en    = (state_q == RUN) || (state_q == RESTART);
    bist_busy  = bist_en;
    bist_done  = (state_q == DONE);
    bist_rd    = op_rd;
    bist_wr    = op_wr;
    bist_wdata = op_wr ? {DW{info.wr_val}} : '0;
  end

  assign bist_addr = addr_q;
  assign bist_fail = fail_q;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl: clean run, repaired fault, unrepairable
// fault, abort, mid-run reset and a single-word range.
module tb_mbist_march_ctrl;

  logic        clk, rst_n;
  logic        run1, en1, wr1, rd1, corr1, err1, busy1, done1, fail1;
  logic [8:0]  addr1, eaddr1;
  logic [31:0] wd1, rdat1;
  logic        run2, en2, wr2, rd2, err2, busy2, done2, fail2;
  logic [8:0]  addr2, eaddr2;
  logic [31:0] wd2, rdat2;

  int checks = 0;
  int errs   = 0;

  mbist_march_ctrl #(.BIST_ADDR_WD(9), .BIST_DATA_WD(32),
                     .BIST_ADDR_START(9'h000), .BIST_ADDR_END(9'h003)) dut1 (
    .clk(clk), .rst_n(rst_n), .bist_run(run1), .bist_en(en1), .bist_addr(addr1),
    .bist_wdata(wd1), .bist_wr(wr1), .bist_rd(rd1), .mem_rdata(rdat1),
    .bist_correct(corr1), .bist_error(err1), .bist_error_addr(eaddr1),
    .bist_busy(busy1), .bist_done(done1), .bist_fail(fail1));

  mbist_march_ctrl #(.BIST_ADDR_WD(9), .BIST_DATA_WD(32),
                     .BIST_ADDR_START(9'h005), .BIST_ADDR_END(9'h005)) dut2 (
    .clk(clk), .rst_n(rst_n), .bist_run(run2), .bist_en(en2), .bist_addr(addr2),
    .bist_wdata(wd2), .bist_wr(wr2), .bist_rd(rd2), .mem_rdata(rdat2),
    .bist_correct(1'b0), .bist_error(err2), .bist_error_addr(eaddr2),
    .bist_busy(busy2), .bist_done(done2), .bist_fail(fail2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory + repair models: faults force bit 0 high until the address is repaired.
  logic [31:0] mem1 [0:511];
  logic [31:0] mem2 [0:511];
  logic [8:0]  f1, f2, rep_addr;
  logic        rep_used, rep_clr, flt;
  int          err_cnt = 0;
  logic [8:0]  last_eaddr;

  assign flt   = ((addr1 == f1) || (addr1 == f2)) && !(rep_used && rep_addr == addr1);
  assign corr1 = rep_used;

  always @(posedge clk) begin
    if (wr1) mem1[addr1] <= wd1;
    if (rd1) rdat1 <= mem1[addr1] | {31'b0, flt};
    if (wr2) mem2[addr2] <= wd2;
    if (rd2) rdat2 <= mem2[addr2];
    if (rep_clr) begin
      rep_used <= 1'b0;
      rep_addr <= '0;
    end else if (err1 && !rep_used) begin
      rep_used <= 1'b1;
      rep_addr <= eaddr1;
    end
  end

  always @(negedge clk) begin
    if (err1) begin
      err_cnt    <= err_cnt + 1;
      last_eaddr <= eaddr1;
    end
  end

  int q_kind [$];
  int q_addr [$];
  int q_val  [$];

  task automatic push_op(input int kind, input int a, input int v);
    q_kind.push_back(kind);
    q_addr.push_back(a);
    q_val.push_back(v);
  endtask

  // kind 1 = read, 0 = write
  task automatic build_seq(input int s, input int e);
    int a;
    q_kind.delete(); q_addr.delete(); q_val.delete();
    for (int el = 0; el < 6; el++)
      for (int i = 0; i <= e - s; i++) begin
        a = (el == 3 || el == 4) ? e - i : s + i;
        case (el)
          0: push_op(0, a, 0);
          1: begin push_op(1, a, 0); push_op(0, a, 1); end
          2: begin push_op(1, a, 1); push_op(0, a, 0); end
          3: begin push_op(1, a, 0); push_op(0, a, 1); end
          4: begin push_op(1, a, 1); push_op(0, a, 0); end
          default: push_op(1, a, 0);
        endcase
      end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_op(input int which, input int j);
    logic        r, w;
    logic [8:0]  a;
    logic [31:0] d, ed;
    if (which == 1) begin r = rd1; w = wr1; a = addr1; d = wd1; end
    else            begin r = rd2; w = wr2; a = addr2; d = wd2; end
    ed = (q_kind[j] == 0 && q_val[j] == 1) ? 32'hFFFF_FFFF : 32'h0;
    chk($sformatf("d%0d_op%0d_rd", which, j), 64'(r), 64'(q_kind[j] == 1));
    chk($sformatf("d%0d_op%0d_wr", which, j), 64'(w), 64'(q_kind[j] == 0));
    chk($sformatf("d%0d_op%0d_addr", which, j), 64'(a), 64'(q_addr[j]));
    chk($sformatf("d%0d_op%0d_wdata", which, j), 64'(d), 64'(ed));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, e0;
    rst_n = 1'b0; run1 = 1'b0; run2 = 1'b0; rep_clr = 1'b1;
    f1 = 9'h1FF; f2 = 9'h1FF;
    repeat (2) tick();
    chk("rst_en", 64'(en1), 0);    chk("rst_busy", 64'(busy1), 0);
    chk("rst_done", 64'(done1), 0); chk("rst_fail", 64'(fail1), 0);
    chk("rst_rd", 64'(rd1), 0);    chk("rst_wr", 64'(wr1), 0);
    chk("rst_err", 64'(err1), 0);  chk("rst_addr", 64'(addr1), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    rep_clr = 1'b0;

    // 1: clean run, N=4
    build_seq(0, 3);
    e0 = err_cnt;
    run1 = 1'b1;
    for (int j = 0; j < 40; j++) begin
      tick();
      chk_op(1, j);
    end
    tick();
    chk("t1_c41_done", 64'(done1), 0);
    chk("t1_c41_rd", 64'(rd1), 0);
    tick();
    chk("t1_c42_done", 64'(done1), 1);
    chk("t1_c42_fail", 64'(fail1), 0);
    chk("t1_c42_en", 64'(en1), 0);
    chk("t1_c42_busy", 64'(busy1), 0);
    tick();
    chk("t1_done_held", 64'(done1), 1);
    chk("t1_no_err", 64'(err_cnt - e0), 0);
    run1 = 1'b0;
    tick();
    chk("t1_idle_done", 64'(done1), 0);

    // 2: address 2 bit 0 stuck at 1, repaired on rerun
    rep_clr = 1'b1; tick(); rep_clr = 1'b0; f1 = 9'd2;
    e0 = err_cnt; cyc = 0;
    run1 = 1'b1;
    do begin tick(); cyc++; end while (!err1 && cyc < 100);
    chk("t2_err_cyc", 64'(cyc), 11);
    chk("t2_err_addr", 64'(eaddr1), 2);
    chk("t2_restart_rd", 64'(rd1), 0);
    chk("t2_restart_wr", 64'(wr1), 0);
    chk("t2_restart_busy", 64'(busy1), 1);
    tick(); cyc++;
    chk("t2_rerun_wr", 64'(wr1), 1);
    chk("t2_rerun_addr", 64'(addr1), 0);
    while (!done1 && cyc < 200) begin tick(); cyc++; end
    chk("t2_done_cyc", 64'(cyc), 53);
    chk("t2_fail", 64'(fail1), 0);
    chk("t2_err_cnt", 64'(err_cnt - e0), 1);
    run1 = 1'b0; tick();

    // 3: faults at 1 and 3; second error exhausts repair
    rep_clr = 1'b1; tick(); rep_clr = 1'b0; f1 = 9'd1; f2 = 9'd3;
    e0 = err_cnt; cyc = 0;
    run1 = 1'b1;
    do begin tick(); cyc++; end while (!err1 && cyc < 100);
    chk("t3_err1_cyc", 64'(cyc), 9);
    chk("t3_err1_addr", 64'(eaddr1), 1);
    do begin tick(); cyc++; end while (!err1 && cyc < 200);
    chk("t3_err2_cyc", 64'(cyc), 22);
    chk("t3_err2_addr", 64'(eaddr1), 3);
    chk("t3_done", 64'(done1), 1);
    chk("t3_fail", 64'(fail1), 1);
    tick();
    chk("t3_err_cnt", 64'(err_cnt - e0), 2);
    chk("t3_fail_held", 64'(fail1), 1);
    run1 = 1'b0; tick();
    chk("t3_clear_done", 64'(done1), 0);
    chk("t3_clear_fail", 64'(fail1), 0);
    f1 = 9'h1FF; f2 = 9'h1FF;
    rep_clr = 1'b1; tick(); rep_clr = 1'b0;

    // 4: abort during E2 (op 14 = w0 @ addr 0)
    run1 = 1'b1;
    repeat (14) tick();
    chk_op(1, 13);
    run1 = 1'b0;
    tick();
    chk("t4_rd", 64'(rd1), 0);     chk("t4_wr", 64'(wr1), 0);
    chk("t4_busy", 64'(busy1), 0); chk("t4_en", 64'(en1), 0);
    chk("t4_done", 64'(done1), 0); chk("t4_fail", 64'(fail1), 0);
    run1 = 1'b1;
    tick();
    chk_op(1, 0);
    tick();
    chk_op(1, 1);

    // 5: reset during E3 (op 24 = w1 @ addr 2)
    repeat (22) tick();
    chk_op(1, 23);
    rst_n = 1'b0;
    #1;
    chk("t5_en", 64'(en1), 0);     chk("t5_busy", 64'(busy1), 0);
    chk("t5_rd", 64'(rd1), 0);     chk("t5_wr", 64'(wr1), 0);
    chk("t5_addr", 64'(addr1), 0); chk("t5_wdata", 64'(wd1), 0);
    chk("t5_err", 64'(err1), 0);   chk("t5_eaddr", 64'(eaddr1), 0);
    chk("t5_done", 64'(done1), 0); chk("t5_fail", 64'(fail1), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5_hold%0d_busy", k), 64'(busy1), 0);
      chk($sformatf("t5_hold%0d_wr", k), 64'(wr1), 0);
    end
    run1 = 1'b0; tick();
    run1 = 1'b1; cyc = 0;
    tick(); cyc++;
    chk_op(1, 0);
    while (!done1 && cyc < 100) begin tick(); cyc++; end
    chk("t5_done_cyc", 64'(cyc), 42);
    chk("t5_fail", 64'(fail1), 0);
    run1 = 1'b0; tick();

    // 6: single-word range START = END = 5
    build_seq(5, 5);
    run2 = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk_op(2, j);
    end
    tick();
    chk("t6_c11_done", 64'(done2), 0);
    tick();
    chk("t6_c12_done", 64'(done2), 1);
    chk("t6_fail", 64'(fail2), 0);
    chk("t6_err", 64'(err2), 0);
    run2 = 1'b0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/mbist_march_ctrl.md
Name: mbist_march_ctrl

Overview:
- Sequencer that drives the BIST side of the memory mux/repair datapath and runs a March C- test over the range BIST_ADDR_START..BIST_ADDR_END.
- Issues one read or write per clock and compares read data against the expected value.
- On a mismatch, reports the failing address to the repair logic and reruns the test once with the repair active.
- Reports pass or fail through bist_done/bist_fail; sits between the MBIST top-level control and the mux.

Parameters:
BIST_ADDR_WD, 9, address width
BIST_DATA_WD, 32, data width
BIST_ADDR_START, 9'h000, first tested address
BIST_ADDR_END, 9'h1F8, last tested address (inclusive, must be >= START)

Ports:
clk  in  1  BIST clock, same net as the mux bist_clk
rst_n  in  1  asynchronous active-low reset
bist_run  in  1  level; rising edge starts a test, low aborts/clears
bist_en  out  1  selects the BIST path in the mux; high while busy
bist_addr  out  BIST_ADDR_WD  memory address
bist_wdata  out  BIST_DATA_WD  write data
bist_wr  out  1  write strobe, one cycle per write
bist_rd  out  1  read strobe, one cycle per read
mem_rdata  in  BIST_DATA_WD  read data, valid the cycle after bist_rd
bist_correct  in  1  repair-slot-used flag from the repair logic
bist_error  out  1  one-cycle mismatch pulse
bist_error_addr  out  BIST_ADDR_WD  failing address, valid with bist_error
bist_busy  out  1  test in progress
bist_done  out  1  test finished, held until bist_run is low
bist_fail  out  1  result, valid while bist_done is high

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: all outputs 0; state IDLE; all counters 0.
- States:
  - IDLE: waits for a rising edge of bist_run, registered with a 1-bit history flop. Edge -> RUN, element 0, addr = START.
  - RUN: one op per cycle; bist_en = bist_busy = 1.
  - RESTART: single cycle, no strobes; lets the repair logic latch the error address; then RUN from element 0.
  - DONE: bist_busy = bist_en = 0; bist_done = 1; bist_fail holds the result. bist_run low -> IDLE with done/fail cleared.
- bist_run low in RUN or RESTART: abort to IDLE next cycle; strobes drop; done and fail stay 0.
- March elements (D0 = all-0, D1 = all-1):
  - E0 up: w0
  - E1 up: r0, w1
  - E2 up: r1, w0
  - E3 down: r0, w1
  - E4 down: r1, w0
  - E5 up: r0
- Two-op elements: read in cycle k, write at the same address in cycle k+1, then the address steps. Single-op elements step every cycle.
- Up elements run START..END; down elements run END..START.
- No idle cycles between elements or addresses.
- Compare pipeline:
  - Each bist_rd registers its expected data and address.
  - Next cycle: mem_rdata != expected -> mismatch.
  - Mismatch drives bist_error = 1 and bist_error_addr = registered address in the following cycle (registered outputs).
- Error handling, evaluated in the cycle the mismatch is detected:
  - bist_correct == 0: the op already issued that cycle completes. Next cycle: error pulse, state RESTART, strobes low.
  - bist_correct == 1: error pulse, then DONE with bist_fail = 1. The repair slot is exhausted.
  - At most one restart per run.
- Completion: the last E5 read is compared. No mismatch -> DONE, bist_fail = 0.
- Latency without errors: N = END - START + 1 words, 10N ops.
  - Start edge sampled at cycle 0.
  - First strobe at cycle 1; last read at cycle 10N.
  - bist_done high at cycle 10N + 2.
- Strobe rules: bist_wr and bist_rd are never high together. Both are low outside RUN.
- Boundary: N = 1 is legal; up and down elements are identical.
- Address counter never leaves [START, END].
- Mismatch on the final E5 read is handled like any other mismatch.

Decomposition:
- Package mbist_pkg holds:
  - element enum E0..E5
  - state enum IDLE/RUN/RESTART/DONE
  - per-element direction and op-pattern constants, as a function or lookup
- Sub-module mbist_data_cmp: the registered expected/address pipeline and comparator that produce the error pulse and address.

Test Plan:
- START=0, END=3, memory model fault-free; bist_run rises at cycle 0. Required:
  - 40 ops in March C- order
  - bist_done = 1 at cycle 42, bist_fail = 0
  - no bist_error
  - bist_en low after done
- Same parameters, bit 0 of address 2 stuck at 1 before repair. Required:
  - one bist_error with bist_error_addr = 2
  - RESTART, then a clean rerun with bist_correct = 1
  - done with fail = 0
- Two faulty addresses, 1 and 3. Required:
  - first error addr 1, restart
  - second error addr 3 while bist_correct = 1
  - done with fail = 1
- bist_run drops during E2. Required:
  - strobes low next cycle, state IDLE
  - bist_done = 0, bist_fail = 0
  - a new rising edge restarts from E0 at address 0
- Reset asserted mid-E3. Required:
  - all outputs 0 immediately
  - after release with bist_run held high, no start until a fresh rising edge
- START = END = 5. Required:
  - 10 ops, all at address 5
  - done at cycle 12
